hazard_tnew_tracker: RTL and testbench
======================================

// Module: hazard_tnew_tracker
// PURPOSE
//  Consumer side of the decoder's Tuse/TnewD/RegWrite/RegDst interface in the 5-stage MIPS pipeline.
//  - Tracks the destination register and remaining Tnew of each in-flight instruction in E, M and W.
//  - Compares these against the Tuse of the instruction in D.
//  - Drives the D-stage stall (bubble into E) and the forwarding selects for the D and E operands.
// PARAMETERS
//  ADDR_W  5   register address width
//  TNEW_W  2   Tnew/Tuse width; Tuse value 2'b11 = operand not read
//  CNT_W   32  stall counter width (STALL_STATS_EN only)
// PORTS
//  clk         in   1       system clock
//  reset_n     in   1       synchronous reset, active-low
//  hold        in   1       1 = whole pipeline frozen this cycle
//  d_rs        in   ADDR_W  D-stage rs address
//  d_rt        in   ADDR_W  D-stage rt address
//  d_tuse_rs   in   TNEW_W  Tuse of rs (3 = unused)
//  d_tuse_rt   in   TNEW_W  Tuse of rt (3 = unused)
//  d_regwrite  in   1       D instruction writes the register file (already branch-qualified)
//  d_wa        in   ADDR_W  D-stage destination address
//  d_tnew      in   TNEW_W  TnewD from the decoder
//  stall       out  1       freeze PC/D-reg; bubble into E
//  fwd_rs_d    out  2       D rs select: 00 RF, 01 E, 10 M, 11 W
//  fwd_rt_d    out  2       D rt select: same encoding
//  fwd_rs_e    out  2       E rs select: 00 reg, 10 M, 11 W
//  fwd_rt_e    out  2       E rt select: same encoding
//  stall_cnt   out  CNT_W   stall cycles counted (STALL_STATS_EN only)
// BEHAVIOUR
//  - State: records E, M, W, each {we, wa, tnew}. E additionally holds {rs, rt}.
//    A record is "live" iff we=1 and wa!=0.
//  - Reset (reset_n=0 at a clk edge): all records cleared to we=0, wa=0, tnew=0, rs=rt=0.
//    Outputs then read stall=0 and all fwd_*=00. stall_cnt=0.
//    Reset overrides hold and takes effect mid-stall.
//  - Advance (hold=0), at each clk edge:
//    - W <= M with tnew = sat_dec(M.tnew).
//    - M <= E with tnew = sat_dec(E.tnew).
//    - E <= bubble (all fields 0) if stall=1.
//    - Otherwise E <= {d_regwrite, d_wa, sat_dec(d_tnew), d_rs, d_rt}.
//    - sat_dec(x) = x==0 ? 0 : x-1. Resulting Tnew: ALU E=1, M=0; load E=2, M=1, W=0.
//  - hold=1: every record keeps its value, with no decrement and no bubble. Hold wins over stall.
//  - All outputs are combinational from the registers plus the current D inputs; zero-cycle latency.
//  - Stall, evaluated per D source s in {rs,rt}:
//    - Skip s if tuse_s==3 or s==0.
//    - stall_s = (E live & E.wa==s & E.tnew>tuse_s) | (M live & M.wa==s & M.tnew>tuse_s).
//    - stall = stall_rs | stall_rt. W never causes a stall.
//  - D forwarding: first match wins, in order E, M, W.
//    - Matching stage: live, wa==s, tnew==0. Result 01/10/11 for E/M/W; no match gives 00.
//    - s==0 always gives 00.
//    - While stall=1, the fwd_*_d values are don't-care.
//  - E forwarding, for E.rs/E.rt against M then W (tnew==0, live): 10/11, else 00.
//  - Comparisons are full ADDR_W equality. Tnew/Tuse compare unsigned.
// CONFIGURATION
//  STALL_STATS_EN defined:
//  - stall_cnt port exists.
//  - Increments on each clk edge where reset_n=1, hold=0 and stall=1.
//  - Saturates at all-ones; it does not wrap.
//  STALL_STATS_EN undefined: no stall_cnt port and no counter logic. All other behaviour is identical.
// TESTING
//  1. Reset, then hold=0 with NOPs -> stall=0; fwd all 00; stall_cnt=0.
//  2. lw $8 (tnew 3), then next D beq $8,$9 (tuse 0):
//     - stall=1 for 2 cycles.
//     - 3rd cycle: stall=0, fwd_rs_d=11 (W).
//     - stall_cnt=2.
//  3. addu $8 (tnew 2), then addu $9,$8,$8 (tuse 1):
//     - no stall.
//     - Next cycle fwd_rs_e=fwd_rt_e=10 (M).
//  4. addu $0 then beq $0 -> stall=0, fwd_rs_d=00 (no tracking of $0).
//  5. ori $8 in M (tnew 0) and lw $8 in E (tnew 2), D beq $8 -> stall=1 (E has priority); no forward from M.
//  6. During stall from scenario 2, assert hold=1 for 3 cycles:
//     - records unchanged; stall stays 1; stall_cnt unchanged.
//     - Deassert hold: sequence resumes as in scenario 2.
//     - Pull reset_n=0 mid-stall: stall=0 the next cycle.

Source files
------------

// File: rtl/hazard_tnew_tracker.sv
// Hazard tracker for the 5-stage MIPS pipeline: consumes the decoder's Tuse/Tnew/RegWrite/RegDst
// for the instruction in D, tracks {we, wa, tnew} of the instructions in E, M and W, and drives
// the D-stage stall plus the D- and E-stage forwarding selects.
// Optional feature: define STALL_STATS_EN to add the saturating stall_cnt output.
module hazard_tnew_tracker #(
    parameter int unsigned ADDR_W = 5,
    parameter int unsigned TNEW_W = 2,
    parameter int unsigned CNT_W  = 32
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              hold,
    input  logic [ADDR_W-1:0] d_rs,
    input  logic [ADDR_W-1:0] d_rt,
    input  logic [TNEW_W-1:0] d_tuse_rs,
    input  logic [TNEW_W-1:0] d_tuse_rt,
    input  logic              d_regwrite,
    input  logic [ADDR_W-1:0] d_wa,
    input  logic [TNEW_W-1:0] d_tnew,
    output logic              stall,
    output logic [1:0]        fwd_rs_d,
    output logic [1:0]        fwd_rt_d,
    output logic [1:0]        fwd_rs_e,
    output logic [1:0]        fwd_rt_e
`ifdef STALL_STATS_EN
    ,
    output logic [CNT_W-1:0]  stall_cnt
`endif
);

    // All-ones Tuse marks an operand the D instruction does not read.
    localparam logic [TNEW_W-1:0] TuseNone = '1;

    logic              e_we_q, e_we_d, m_we_q, m_we_d, w_we_q, w_we_d;
    logic [ADDR_W-1:0] e_wa_q, e_wa_d, m_wa_q, m_wa_d, w_wa_q, w_wa_d;
    logic [TNEW_W-1:0] e_tnew_q, e_tnew_d, m_tnew_q, m_tnew_d, w_tnew_q, w_tnew_d;
    logic [ADDR_W-1:0] e_rs_q, e_rs_d, e_rt_q, e_rt_d;
    logic              e_live, m_live, w_live;
    logic              stall_rs, stall_rt;

    function automatic logic [TNEW_W-1:0] sat_dec(input logic [TNEW_W-1:0] x);
        return (x == '0) ? '0 : x - TNEW_W'(1);
    endfunction

    // Producer still too far from its result for the consumer's Tuse.
    function automatic logic late(input logic live, input logic [ADDR_W-1:0] wa,
                                  input logic [TNEW_W-1:0] tnew, input logic [ADDR_W-1:0] src,
                                  input logic [TNEW_W-1:0] tuse);
        return live && (wa == src) && (tnew > tuse);
    endfunction

    // Producer holds a finished result for this source.
    function automatic logic ready(input logic live, input logic [ADDR_W-1:0] wa,
                                   input logic [TNEW_W-1:0] tnew, input logic [ADDR_W-1:0] src);
        return live && (wa == src) && (tnew == '0);
    endfunction

    assign e_live = e_we_q && (e_wa_q != '0);
    assign m_live = m_we_q && (m_wa_q != '0);
    assign w_live = w_we_q && (w_wa_q != '0);

    // Stall decision per D source; W never stalls since its tnew is always 0.
    always_comb begin
        stall_rs = 1'b0;
        stall_rt = 1'b0;
        if (d_tuse_rs != TuseNone && d_rs != '0) begin
            stall_rs = late(e_live, e_wa_q, e_tnew_q, d_rs, d_tuse_rs) ||
                       late(m_live, m_wa_q, m_tnew_q, d_rs, d_tuse_rs);
        end
        if (d_tuse_rt != TuseNone && d_rt != '0) begin
            stall_rt = late(e_live, e_wa_q, e_tnew_q, d_rt, d_tuse_rt) ||
                       late(m_live, m_wa_q, m_tnew_q, d_rt, d_tuse_rt);
        end
        stall = stall_rs || stall_rt;
    end

    // Forwarding selects: youngest ready producer wins; $0 is never forwarded.
    always_comb begin
        fwd_rs_d = 2'b00;
        fwd_rt_d = 2'b00;
        fwd_rs_e = 2'b00;
        fwd_rt_e = 2'b00;
        if (d_rs != '0) begin
            if (ready(e_live, e_wa_q, e_tnew_q, d_rs))      fwd_rs_d = 2'b01;
            else if (ready(m_live, m_wa_q, m_tnew_q, d_rs)) fwd_rs_d = 2'b10;
            else if (ready(w_live, w_wa_q, w_tnew_q, d_rs)) fwd_rs_d = 2'b11;
        end
        if (d_rt != '0) begin
            if (ready(e_live, e_wa_q, e_tnew_q, d_rt))      fwd_rt_d = 2'b01;
            else if (ready(m_live, m_wa_q, m_tnew_q, d_rt)) fwd_rt_d = 2'b10;
            else if (ready(w_live, w_wa_q, w_tnew_q, d_rt)) fwd_rt_d = 2'b11;
        end
        // A live record never has wa==0, so E.rs/E.rt==0 cannot match here.
        if (ready(m_live, m_wa_q, m_tnew_q, e_rs_q))      fwd_rs_e = 2'b10;
        else if (ready(w_live, w_wa_q, w_tnew_q, e_rs_q)) fwd_rs_e = 2'b11;
        if (ready(m_live, m_wa_q, m_tnew_q, e_rt_q))      fwd_rt_e = 2'b10;
        else if (ready(w_live, w_wa_q, w_tnew_q, e_rt_q)) fwd_rt_e = 2'b11;
    end

    // Pipeline advance: hold freezes everything, stall inserts a bubble into E.
    always_comb begin
        e_we_d   = e_we_q;
        e_wa_d   = e_wa_q;
        e_tnew_d = e_tnew_q;
        e_rs_d   = e_rs_q;
        e_rt_d   = e_rt_q;
        m_we_d   = m_we_q;
        m_wa_d   = m_wa_q;
        m_tnew_d = m_tnew_q;
        w_we_d   = w_we_q;
        w_wa_d   = w_wa_q;
        w_tnew_d = w_tnew_q;
        if (!hold) begin
            w_we_d   = m_we_q;
            w_wa_d   = m_wa_q;
            w_tnew_d = sat_dec(m_tnew_q);
            m_we_d   = e_we_q;
            m_wa_d   = e_wa_q;
            m_tnew_d = sat_dec(e_tnew_q);
            if (stall) begin
                e_we_d   = 1'b0;
                e_wa_d   = '0;
                e_tnew_d = '0;
                e_rs_d   = '0;
                e_rt_d   = '0;
            end else begin
                e_we_d   = d_regwrite;
                e_wa_d   = d_wa;
                e_tnew_d = sat_dec(d_tnew);
                e_rs_d   = d_rs;
                e_rt_d   = d_rt;
            end
        end
    end

    // Stage record registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            e_we_q   <= 1'b0;
            e_wa_q   <= '0;
            e_tnew_q <= '0;
            e_rs_q   <= '0;
            e_rt_q   <= '0;
            m_we_q   <= 1'b0;
            m_wa_q   <= '0;
            m_tnew_q <= '0;
            w_we_q   <= 1'b0;
            w_wa_q   <= '0;
            w_tnew_q <= '0;
        end else begin
            e_we_q   <= e_we_d;
            e_wa_q   <= e_wa_d;
            e_tnew_q <= e_tnew_d;
            e_rs_q   <= e_rs_d;
            e_rt_q   <= e_rt_d;
            m_we_q   <= m_we_d;
            m_wa_q   <= m_wa_d;
            m_tnew_q <= m_tnew_d;
            w_we_q   <= w_we_d;
            w_wa_q   <= w_wa_d;
            w_tnew_q <= w_tnew_d;
        end
    end

`ifdef STALL_STATS_EN
    logic [CNT_W-1:0] cnt_q;

    // Saturating count of cycles in which the pipeline actually stalled.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else if (!hold && stall && cnt_q != '1) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    assign stall_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_hazard_tnew_tracker.sv
// Self-checking bench for hazard_tnew_tracker: directed vector table, hand-written
// hold/reset sequences, then randomized traffic against a time-based reference model.
module tb_hazard_tnew_tracker;

    logic       clk = 1'b0;
    logic       reset_n, hold;
    logic [4:0] d_rs, d_rt, d_wa;
    logic [1:0] d_tuse_rs, d_tuse_rt, d_tnew;
    logic       d_regwrite;
    logic       stall;
    logic [1:0] fwd_rs_d, fwd_rt_d, fwd_rs_e, fwd_rt_e;
`ifdef STALL_STATS_EN
    logic [31:0] stall_cnt;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    hazard_tnew_tracker dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .hold       (hold),
        .d_rs       (d_rs),
        .d_rt       (d_rt),
        .d_tuse_rs  (d_tuse_rs),
        .d_tuse_rt  (d_tuse_rt),
        .d_regwrite (d_regwrite),
        .d_wa       (d_wa),
        .d_tnew     (d_tnew),
        .stall      (stall),
        .fwd_rs_d   (fwd_rs_d),
        .fwd_rt_d   (fwd_rt_d),
        .fwd_rs_e   (fwd_rs_e),
        .fwd_rt_e   (fwd_rt_e)
`ifdef STALL_STATS_EN
        ,
        .stall_cnt  (stall_cnt)
`endif
    );

    task automatic check(input string name, input longint act, input longint exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input int rs, input int tu_rs, input int rt, input int tu_rt,
                         input int we, input int wa, input int tnew);
        d_rs = 5'(rs); d_tuse_rs = 2'(tu_rs);
        d_rt = 5'(rt); d_tuse_rt = 2'(tu_rt);
        d_regwrite = 1'(we); d_wa = 5'(wa); d_tnew = 2'(tnew);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        bit rst; bit hld;
        int rs; int tu_rs; int rt; int tu_rt; int we; int wa; int tnew;
        bit chk; bit chk_d;
        int st; int frs_d; int frt_d; int frs_e; int frt_e;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(bit rst, bit hld, int rs, int tu_rs, int rt, int tu_rt, int we,
                                int wa, int tnew, bit chk, bit chk_d, int st, int a, int b,
                                int c, int d);
        vec_t v;
        v.rst = rst; v.hld = hld; v.rs = rs; v.tu_rs = tu_rs; v.rt = rt; v.tu_rt = tu_rt;
        v.we = we; v.wa = wa; v.tnew = tnew; v.chk = chk; v.chk_d = chk_d;
        v.st = st; v.frs_d = a; v.frt_d = b; v.frs_e = c; v.frt_e = d;
        return v;
    endfunction

    function automatic vec_t rst_row();
        return mk(1, 0, 0, 3, 0, 3, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endfunction

    function automatic vec_t nop_row();
        return mk(0, 0, 0, 3, 0, 3, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0);
    endfunction

    // ---------------- reference model ----------------
    // Each in-flight producer remembers the absolute (advance-counted) time its result appears.
    typedef struct { bit we; int wa; int ready_at; int rs; int rt; } rec_t;
    rec_t   pipe[3];   // 0=E, 1=M, 2=W
    int     now;
    longint m_cnt;

    function automatic int remaining(rec_t r);
        return (r.ready_at > now) ? r.ready_at - now : 0;
    endfunction

    function automatic bit live(rec_t r);
        return r.we && r.wa != 0;
    endfunction

    function automatic int exp_stall_src(int s, int tu);
        if (tu == 3 || s == 0) return 0;
        for (int k = 0; k < 2; k++)
            if (live(pipe[k]) && pipe[k].wa == s && remaining(pipe[k]) > tu) return 1;
        return 0;
    endfunction

    function automatic int exp_fwd_d(int s);
        if (s == 0) return 0;
        for (int k = 0; k < 3; k++)
            if (live(pipe[k]) && pipe[k].wa == s && remaining(pipe[k]) == 0) return k + 1;
        return 0;
    endfunction

    function automatic int exp_fwd_e(int s);
        for (int k = 1; k < 3; k++)
            if (live(pipe[k]) && pipe[k].wa == s && remaining(pipe[k]) == 0) return k + 1;
        return 0;
    endfunction

    task automatic model_clear();
        for (int k = 0; k < 3; k++) pipe[k] = '{0, 0, 0, 0, 0};
        m_cnt = 0;
    endtask

    task automatic model_edge(input int st);
        if (!reset_n) begin
            model_clear();
        end else if (!hold) begin
            if (st != 0) m_cnt++;
            pipe[2] = pipe[1];
            pipe[1] = pipe[0];
            if (st != 0) pipe[0] = '{0, 0, 0, 0, 0};
            else pipe[0] = '{d_regwrite, int'(d_wa),
                             now + 1 + ((d_tnew > 0) ? int'(d_tnew) - 1 : 0),
                             int'(d_rs), int'(d_rt)};
            now++;
        end
    endtask

    initial begin
        reset_n = 1'b0;
        hold    = 1'b0;
        drive(0, 3, 0, 3, 0, 0, 0);
        now = 0;
        model_clear();

        // Reset then NOPs: everything idle.
        tbl.push_back(rst_row());
        tbl.push_back(nop_row());
        tbl.push_back(nop_row());
        // lw $8 then beq $8,$9: two stall cycles, then forward from W.
        tbl.push_back(rst_row());
        tbl.push_back(mk(0, 0, 0, 1, 0, 3, 1, 8, 3, 1, 1, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 8, 0, 9, 0, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 8, 0, 9, 0, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 8, 0, 9, 0, 0, 0, 0, 1, 1, 0, 3, 0, 0, 0));
        // addu $8 then addu $9,$8,$8: no stall, then E operands from M.
        tbl.push_back(rst_row());
        tbl.push_back(mk(0, 0, 1, 1, 2, 1, 1, 8, 2, 1, 1, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 8, 1, 8, 1, 1, 9, 2, 1, 1, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 3, 0, 3, 0, 0, 0, 1, 1, 0, 0, 0, 2, 2));
        // addu $0 then beq $0,$0: $0 is never tracked.
        tbl.push_back(rst_row());
        tbl.push_back(mk(0, 0, 1, 1, 2, 1, 1, 0, 2, 1, 1, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0));
        // ori $8 in M, lw $8 in E; unread operand (tuse 3) under hold, then beq $8 stalls.
        tbl.push_back(rst_row());
        tbl.push_back(mk(0, 0, 0, 1, 0, 3, 1, 8, 2, 1, 1, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 1, 0, 3, 1, 8, 3, 1, 1, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 1, 8, 3, 8, 3, 0, 0, 0, 1, 1, 0, 2, 2, 0, 0));
        tbl.push_back(mk(0, 0, 8, 0, 0, 3, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 8, 0, 0, 3, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0));
        // Two ready producers of $8 in E and M: E wins.
        tbl.push_back(rst_row());
        tbl.push_back(mk(0, 0, 0, 3, 0, 3, 1, 8, 1, 1, 1, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 3, 0, 3, 1, 8, 1, 1, 1, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 8, 0, 8, 2, 0, 0, 0, 1, 1, 0, 1, 1, 0, 0));

        foreach (tbl[i]) begin
            reset_n = !tbl[i].rst;
            hold    = tbl[i].hld;
            drive(tbl[i].rs, tbl[i].tu_rs, tbl[i].rt, tbl[i].tu_rt, tbl[i].we, tbl[i].wa,
                  tbl[i].tnew);
            @(negedge clk);
            if (tbl[i].chk) begin
                check($sformatf("vec%0d stall", i), stall, tbl[i].st);
                check($sformatf("vec%0d fwd_rs_e", i), fwd_rs_e, tbl[i].frs_e);
                check($sformatf("vec%0d fwd_rt_e", i), fwd_rt_e, tbl[i].frt_e);
                if (tbl[i].chk_d) begin
                    check($sformatf("vec%0d fwd_rs_d", i), fwd_rs_d, tbl[i].frs_d);
                    check($sformatf("vec%0d fwd_rt_d", i), fwd_rt_d, tbl[i].frt_d);
                end
            end
            step();
        end

        // Hold during a load-use stall, then reset in the middle of a stall.
        reset_n = 1'b0; hold = 1'b0; drive(0, 3, 0, 3, 0, 0, 0); step();
        reset_n = 1'b1;
        drive(0, 1, 0, 3, 1, 8, 3); step();
        drive(8, 0, 9, 0, 0, 0, 0);
        @(negedge clk); check("hold pre stall", stall, 1); step();
        hold = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("hold stall kept", stall, 1);
`ifdef STALL_STATS_EN
            check("hold cnt frozen", stall_cnt, 1);
`endif
            step();
        end
        hold = 1'b0;
        @(negedge clk); check("resume stall", stall, 1); step();
        @(negedge clk);
        check("resume release", stall, 0);
        check("resume fwd_rs_d W", fwd_rs_d, 3);
`ifdef STALL_STATS_EN
        check("resume cnt", stall_cnt, 2);
`endif
        step();
        drive(0, 1, 0, 3, 1, 8, 3); step();
        drive(8, 0, 9, 0, 0, 0, 0);
        @(negedge clk); check("pre-reset stall", stall, 1);
        reset_n = 1'b0; step(); reset_n = 1'b1;
        @(negedge clk); check("mid-stall reset", stall, 0);
`ifdef STALL_STATS_EN
        check("mid-stall reset cnt", stall_cnt, 0);
`endif
        step();

        // Randomized traffic against the reference model.
        reset_n = 1'b0; hold = 1'b0; drive(0, 3, 0, 3, 0, 0, 0); step();
        now = 0;
        model_clear();
        for (int c = 0; c < 3000; c++) begin
            int es;
            reset_n = ($urandom_range(0, 99) < 2) ? 1'b0 : 1'b1;
            hold    = ($urandom_range(0, 99) < 15) ? 1'b1 : 1'b0;
            drive($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                  $urandom_range(0, 3), $urandom_range(0, 1), $urandom_range(0, 3),
                  $urandom_range(0, 3));
            @(negedge clk);
            es = exp_stall_src(d_rs, d_tuse_rs) | exp_stall_src(d_rt, d_tuse_rt);
            check("rnd stall", stall, es);
            check("rnd fwd_rs_e", fwd_rs_e, exp_fwd_e(pipe[0].rs));
            check("rnd fwd_rt_e", fwd_rt_e, exp_fwd_e(pipe[0].rt));
            if (es == 0) begin
                check("rnd fwd_rs_d", fwd_rs_d, exp_fwd_d(d_rs));
                check("rnd fwd_rt_d", fwd_rt_d, exp_fwd_d(d_rt));
            end
`ifdef STALL_STATS_EN
            check("rnd stall_cnt", stall_cnt, m_cnt);
`endif
            model_edge(es);
            step();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
